sdram_cmd_arbiter: RTL and testbench

- Sits between the SDRAM FIFO control block and the SDRAM command/timing core; the core executes one command at a time.
- Arbitrates between three requesters: burst write, burst read and auto-refresh.
- Issues one command at a time over a valid/ready handshake, counts data beats, and steers per-beat acks back to the write or read side.
- Enforces refresh priority and write-streak fairness so reads are never starved by a continuously full write FIFO.

---
 rtl/sdram_cmd_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_arbiter.sv
// Purpose : picks one of refresh / burst-read / burst-write, issues it to the SDRAM core, steers beat acks.
// Latency : command registered one edge after selection in IDLE; beat acks are same-cycle (combinational).
// Backpress: cmd_valid and the latched command are held until cmd_ready; bursts pace entirely on the beat strobe.
//
// Ports:
//   clk_ref, rst                  - control clock, synchronous active-high reset
//   init_done                     - SDRAM init finished; nothing is granted before it
//   wr_req/wr_addr/wr_len/wr_ack  - write requester; wr_ack is the FIFO read strobe per beat
//   rd_req/rd_addr/rd_len/rd_ack  - read requester; rd_ack is the FIFO write strobe per beat
//   ref_req/ref_ack               - refresh timer request, one-cycle completion pulse
//   cmd_valid/cmd_ready/cmd_type/cmd_addr/cmd_len - command handshake to the core
//   beat, ref_done                - core data-beat strobe and refresh-complete pulse
//   busy, err_timeout             - not-idle flag, sticky beat-timeout error
module sdram_cmd_arbiter #(
    parameter int ADDR_W        = 24,
    parameter int LEN_W         = 10,
    parameter int MAX_WR_STREAK = 4,
    parameter int BEAT_TIMEOUT  = 1023
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_ack,
    input  logic              ref_req,
    output logic              ref_ack,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              beat,
    input  logic              ref_done,
    output logic              busy,
    output logic              err_timeout
);

    localparam int STREAK_W = $clog2(MAX_WR_STREAK) + 1;
    localparam int TO_W     = $clog2(BEAT_TIMEOUT + 1);

    localparam logic [1:0] CMD_WR  = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [TO_W-1:0]     TO_LIMIT   = TO_W'(BEAT_TIMEOUT);
    localparam logic [TO_W-1:0]     TO_ONE     = TO_W'(1);
    localparam logic [LEN_W-1:0]    LEN_ONE    = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BURST,
        ST_REFRESH
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [LEN_W-1:0]    beat_cnt;
    logic [TO_W-1:0]     idle_cnt;

    logic              read_forced;
    logic              sel_ref;
    logic              sel_rd;
    logic              sel_wr;
    logic [LEN_W-1:0]  beat_cnt_inc;
    logic [TO_W-1:0]   idle_cnt_inc;
    logic              burst_beat;

    // Reads jump ahead of writes once the write streak has used up its allowance.
    assign read_forced = rd_req && (streak >= STREAK_MAX);
    assign sel_ref     = init_done && ref_req;
    assign sel_rd      = init_done && !ref_req && rd_req && (read_forced || !wr_req);
    assign sel_wr      = init_done && !ref_req && wr_req && !read_forced;

    assign beat_cnt_inc = beat_cnt + LEN_ONE;
    assign idle_cnt_inc = idle_cnt + TO_ONE;

    // Acks follow the beat strobe in the same cycle; a reset cycle suppresses them.
    assign burst_beat = (state == ST_BURST) && beat && !rst;
    assign wr_ack     = burst_beat && (cmd_type == CMD_WR);
    assign rd_ack     = burst_beat && (cmd_type == CMD_RD);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_valid   <= 1'b0;
            cmd_type    <= CMD_WR;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            ref_ack     <= 1'b0;
            err_timeout <= 1'b0;
            streak      <= '0;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
        end else begin
            ref_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_ref) begin
                        cmd_type  <= CMD_REF;
                        cmd_addr  <= '0;
                        cmd_len   <= '0;
                        cmd_valid <= 1'b1;
                        state     <= ST_ISSUE;
                    end else if (sel_rd) begin
                        cmd_type  <= CMD_RD;
                        cmd_addr  <= rd_addr;
                        cmd_len   <= rd_len;
                        cmd_valid <= 1'b1;
                        streak    <= '0;
                        state     <= ST_ISSUE;
                    end else if (sel_wr) begin
                        cmd_type  <= CMD_WR;
                        cmd_addr  <= wr_addr;
                        cmd_len   <= wr_len;
                        cmd_valid <= 1'b1;
                        // Only writes that bypass a waiting read count toward the streak.
                        if (!rd_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_SAT) begin
                            streak <= streak + STREAK_ONE;
                        end
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        beat_cnt  <= '0;
                        idle_cnt  <= '0;
                        if (cmd_type == CMD_REF) begin
                            state <= ST_REFRESH;
                        end else if (cmd_len == '0) begin
                            // Zero-length burst: handshake only, no data phase.
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_BURST;
                        end
                    end
                end

                ST_BURST: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt_inc;
                        idle_cnt <= '0;
                        if (beat_cnt_inc == cmd_len) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        idle_cnt <= idle_cnt_inc;
                        if (idle_cnt_inc == TO_LIMIT) begin
                            err_timeout <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end

                ST_REFRESH: begin
                    if (ref_done) begin
                        ref_ack <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Purpose : self-checking bench for sdram_cmd_arbiter (vector table, directed corner sequences, random traffic).
// Latency : bench drives inputs 1 time unit after each rising edge and samples outputs 1 unit later.
// Backpress: the bench plays the SDRAM core, stalling cmd_ready and spacing beats.
module tb_sdram_cmd_arbiter;

    localparam int ADDR_W        = 24;
    localparam int LEN_W         = 10;
    localparam int MAX_WR_STREAK = 4;
    localparam int BEAT_TIMEOUT  = 1023;

    logic              clk_ref = 1'b0;
    logic              rst;
    logic              init_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_ack;
    logic              ref_req;
    logic              ref_ack;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              beat;
    logic              ref_done;
    logic              busy;
    logic              err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    sdram_cmd_arbiter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .MAX_WR_STREAK(MAX_WR_STREAK), .BEAT_TIMEOUT(BEAT_TIMEOUT)
    ) dut (
        .clk_ref(clk_ref), .rst(rst), .init_done(init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .beat(beat), .ref_done(ref_done), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk_ref = ~clk_ref;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       init;
        logic       ref_r;
        logic       wr;
        logic       rd;
        logic       exp_vld;
        logic [1:0] exp_type;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; init_done = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; ref_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
        cmd_ready = 1'b0; beat = 1'b0; ref_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int k = 0;
        while (!cmd_valid && k < 40) begin
            tick();
            k++;
        end
        check("grant_arrives", {31'd0, cmd_valid}, 32'd1);
    endtask

    // Stall the handshake for 'delay' cycles; the latched command must not move.
    task automatic handshake(input int delay, input logic [1:0] et,
                             input logic [ADDR_W-1:0] ea, input logic [LEN_W-1:0] el);
        for (int i = 0; i < delay; i++) begin
            cmd_ready = 1'b0;
            tick();
            check("stall_valid", {31'd0, cmd_valid}, 32'd1);
            check("stall_type", {30'd0, cmd_type}, {30'd0, et});
            check("stall_len", {22'd0, cmd_len}, {22'd0, el});
            if (et != 2'b10) check("stall_addr", {8'd0, cmd_addr}, {8'd0, ea});
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("valid_drop", {31'd0, cmd_valid}, 32'd0);
    endtask

    // Deliver n beats with random gaps; every beat must be acked on the right side only.
    task automatic do_beats(input int n, input int gapmax, input logic is_rd, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(gapmax, 0);
            for (int g = 0; g < gap; g++) begin
                beat = 1'b0;
                #1;
                check("no_ack_in_gap", {30'd0, wr_ack, rd_ack}, 32'd0);
                tick();
            end
            beat = 1'b1;
            #1;
            check("beat_ack", {30'd0, wr_ack, rd_ack}, is_rd ? 32'd1 : 32'd2);
            if (wr_ack || rd_ack) acks++;
            tick();
            beat = 1'b0;
        end
    endtask

    vec_t vecs[8];
    int   pat[10];
    int   acks;
    int   streak_m;
    int   exp_t;
    int   exp_l;
    logic [ADDR_W-1:0] exp_a;
    logic stuck;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset state
        do_reset();
        check("rst_outputs", {22'd0, cmd_valid, cmd_type, wr_ack, rd_ack, ref_ack, busy, err_timeout},
              32'd0);
        check("rst_addr", {8'd0, cmd_addr}, 32'd0);
        check("rst_len", {22'd0, cmd_len}, 32'd0);

        // Vector table: first grant out of a clean reset
        for (int i = 0; i < 8; i++) begin
            do_reset();
            init_done = vecs[i].init;
            ref_req = vecs[i].ref_r; wr_req = vecs[i].wr; rd_req = vecs[i].rd;
            wr_addr = ADDR_W'(24'h000110 + i); rd_addr = ADDR_W'(24'h000220 + i);
            wr_len = 10'd3; rd_len = 10'd5;
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, cmd_valid}, {31'd0, vecs[i].exp_vld});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_vld});
            if (vecs[i].exp_vld) begin
                check($sformatf("vec%0d_type", i), {30'd0, cmd_type}, {30'd0, vecs[i].exp_type});
                exp_l = (vecs[i].exp_type == 2'b00) ? 3 : (vecs[i].exp_type == 2'b01) ? 5 : 0;
                check($sformatf("vec%0d_len", i), {22'd0, cmd_len}, exp_l);
            end
        end

        // No grant before init_done; 8-beat write with a 3-cycle stall
        do_reset();
        wr_req = 1'b1; wr_addr = 24'h000100; wr_len = 10'd8;
        stuck = 1'b0;
        repeat (20) begin
            tick();
            if (cmd_valid) stuck = 1'b1;
        end
        check("no_grant_without_init", {31'd0, stuck}, 32'd0);
        init_done = 1'b1;
        tick();
        check("init_grant_valid", {31'd0, cmd_valid}, 32'd1);
        check("init_grant_type", {30'd0, cmd_type}, 32'd0);
        check("init_grant_addr", {8'd0, cmd_addr}, 32'h100);
        wr_req = 1'b0;
        handshake(3, 2'b00, 24'h000100, 10'd8);
        do_beats(8, 2, 1'b0, acks);
        check("wr8_ack_count", acks, 32'd8);
        check("wr8_busy_falls", {31'd0, busy}, 32'd0);

        // Refresh beats simultaneous write/read, then the write follows
        do_reset();
        init_done = 1'b1; ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 24'h000A00; wr_len = 10'd2; rd_addr = 24'h000B00; rd_len = 10'd2;
        tick();
        check("ref_first_type", {30'd0, cmd_type}, 32'd2);
        check("ref_first_len", {22'd0, cmd_len}, 32'd0);
        ref_req = 1'b0;
        handshake(1, 2'b10, '0, '0);
        tick(); tick();
        check("ref_wait_busy", {31'd0, busy}, 32'd1);
        check("ref_no_early_ack", {31'd0, ref_ack}, 32'd0);
        ref_done = 1'b1;
        tick();
        ref_done = 1'b0;
        check("ref_ack_pulse", {31'd0, ref_ack}, 32'd1);
        tick();
        check("ref_ack_one_cycle", {31'd0, ref_ack}, 32'd0);
        check("after_ref_valid", {31'd0, cmd_valid}, 32'd1);
        check("after_ref_type", {30'd0, cmd_type}, 32'd0);

        // Write-streak fairness: W,W,W,W,R,W,W,W,W,R
        do_reset();
        init_done = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 24'h001000; rd_addr = 24'h002000; wr_len = 10'd4; rd_len = 10'd4;
        for (int g = 0; g < 10; g++) begin
            wait_grant();
            check($sformatf("fair_grant%0d_type", g), {30'd0, cmd_type}, pat[g]);
            handshake(0, pat[g][1:0], pat[g] ? rd_addr : wr_addr, 10'd4);
            do_beats(4, 1, pat[g] != 0, acks);
            check($sformatf("fair_grant%0d_acks", g), acks, 32'd4);
        end

        // Beat timeout on a 16-beat read that stops after 5 beats
        do_reset();
        init_done = 1'b1; rd_req = 1'b1; rd_addr = 24'h00C000; rd_len = 10'd16;
        tick();
        check("to_grant_type", {30'd0, cmd_type}, 32'd1);
        rd_req = 1'b0;
        handshake(0, 2'b01, 24'h00C000, 10'd16);
        do_beats(5, 1, 1'b1, acks);
        check("to_ack_count", acks, 32'd5);
        repeat (BEAT_TIMEOUT - 1) tick();
        check("to_not_yet", {30'd0, err_timeout, busy}, 32'd1);
        tick();
        check("to_fires", {30'd0, err_timeout, busy}, 32'd2);
        beat = 1'b1;
        #1;
        check("beat_outside_burst", {30'd0, wr_ack, rd_ack}, 32'd0);
        beat = 1'b0;
        repeat (5) tick();
        check("to_sticky", {31'd0, err_timeout}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to_cleared_by_rst", {31'd0, err_timeout}, 32'd0);

        // Reset during the 3rd beat of an 8-beat write
        do_reset();
        init_done = 1'b1; wr_req = 1'b1; wr_addr = 24'h003300; wr_len = 10'd8;
        tick();
        wr_req = 1'b0;
        handshake(0, 2'b00, 24'h003300, 10'd8);
        do_beats(2, 0, 1'b0, acks);
        beat = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs", {22'd0, cmd_valid, cmd_type, wr_ack, rd_ack, ref_ack, busy, err_timeout},
              32'd0);
        check("midrst_addr", {8'd0, cmd_addr}, 32'd0);
        tick();
        check("midrst_no_more_ack", {31'd0, wr_ack}, 32'd0);
        beat = 1'b0;
        wr_req = 1'b1; wr_addr = 24'h004400; wr_len = 10'd1;
        wait_grant();
        check("midrst_regrant_type", {30'd0, cmd_type}, 32'd0);
        check("midrst_regrant_addr", {8'd0, cmd_addr}, 32'h4400);
        wr_req = 1'b0;
        handshake(1, 2'b00, 24'h004400, 10'd1);
        do_beats(1, 1, 1'b0, acks);
        check("midrst_regrant_acks", acks, 32'd1);

        // Random traffic against a priority/streak model
        do_reset();
        init_done = 1'b1;
        streak_m = 0;
        for (int t = 0; t < 60; t++) begin
            ref_req = ($urandom_range(3, 0) == 0);
            wr_req = $urandom_range(1, 0);
            rd_req = $urandom_range(1, 0);
            if (!ref_req && !wr_req && !rd_req) wr_req = 1'b1;
            wr_addr = ADDR_W'($urandom); rd_addr = ADDR_W'($urandom);
            wr_len = LEN_W'($urandom_range(5, 0)); rd_len = LEN_W'($urandom_range(5, 0));
            wait_grant();
            if (!cmd_valid) break;
            if (ref_req) exp_t = 2;
            else if (rd_req && streak_m >= MAX_WR_STREAK) exp_t = 1;
            else if (wr_req) exp_t = 0;
            else exp_t = 1;
            if (exp_t == 1) streak_m = 0;
            else if (exp_t == 0) streak_m = rd_req ? ((streak_m < 7) ? streak_m + 1 : 7) : 0;
            exp_l = (exp_t == 0) ? int'(wr_len) : (exp_t == 1) ? int'(rd_len) : 0;
            exp_a = (exp_t == 0) ? wr_addr : rd_addr;
            check("rnd_type", {30'd0, cmd_type}, exp_t);
            check("rnd_len", {22'd0, cmd_len}, exp_l);
            if (exp_t != 2) check("rnd_addr", {8'd0, cmd_addr}, {8'd0, exp_a});
            ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
            handshake($urandom_range(2, 0), 2'(exp_t), exp_a, LEN_W'(exp_l));
            if (exp_t == 2) begin
                repeat ($urandom_range(2, 0)) tick();
                check("rnd_ref_busy", {31'd0, busy}, 32'd1);
                ref_done = 1'b1;
                tick();
                ref_done = 1'b0;
                check("rnd_ref_ack", {31'd0, ref_ack}, 32'd1);
            end else begin
                do_beats(exp_l, 2, exp_t == 1, acks);
                check("rnd_ack_count", acks, exp_l);
            end
            check("rnd_idle_after", {31'd0, busy}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
